multicycle_ctrl_fsm: RTL and testbench

//  Parametrised Moore control FSM for the multi-cycle RV32I datapath. Decodes opcode/funct3 and sequences

---
 rtl/multicycle_ctrl_fsm.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_fsm
// Description : Moore control FSM for a multi-cycle RV32I datapath. Decodes
//               opcode/funct3 and sequences fetch, decode, execute, memory
//               and writeback. Memory accesses can stall on a mem_ready
//               handshake with an optional timeout. Illegal instructions and
//               bus timeouts end in a sticky TRAP state that only reset
//               leaves.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   STATE_W       width of fsm_state debug output (>= 5)
//   MEM_HANDSHAKE 1: FETCH/MEM_READ/MEM_WRITE wait for mem_ready; 0: ignore it
//   MEM_TIMEOUT   wait cycles before bus_error (0 disables, max 255)
//   TRAP_EN       1: illegal instructions trap; 0: treated as NOP (to FETCH)
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   opcode[6:0], funct3[2:0]      instruction fields from the IR
//   zero_flag, lt_flag, ltu_flag  ALU compare flags for branches
//   mem_ready                     memory finished the current access
//   adr_src                       0 = PC, 1 = ALU result register
//   ir_write, reg_write,
//   pc_update, mem_write,
//   mem_read                      datapath enables
//   pc_src[1:0]                   0 = INCREMENT, 1 = JUMP, 2 = ALU_RESULT
//   branch                        branch-evaluate cycle
//   alu_src_a[1:0]                0 = RD1, 1 = OLD_PC, 2 = ZERO
//   alu_src_b[1:0]                0 = IMM_EXT, 1 = RD2, 2 = constant 4
//   alu_op[2:0]                   000 add, 001 sub/compare, 010 R, 011 I
//   result_src                    0 = ALU_OUT, 1 = DATA
//   illegal_instr, bus_error      sticky trap cause flags
//   fsm_state[STATE_W-1:0]        current state, zero-extended
// ============================================================================
module multicycle_ctrl_fsm #(
  parameter int STATE_W       = 5,
  parameter int MEM_HANDSHAKE = 1,
  parameter int MEM_TIMEOUT   = 255,
  parameter int TRAP_EN       = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               zero_flag,
  input  logic               lt_flag,
  input  logic               ltu_flag,
  input  logic               mem_ready,
  output logic               adr_src,
  output logic               ir_write,
  output logic               reg_write,
  output logic               pc_update,
  output logic [1:0]         pc_src,
  output logic               mem_write,
  output logic               mem_read,
  output logic               branch,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_op,
  output logic               result_src,
  output logic               illegal_instr,
  output logic               bus_error,
  output logic [STATE_W-1:0] fsm_state
);

  // Opcodes
  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_I      = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

  // Datapath select encodings
  localparam logic       c_ADR_PC       = 1'b0;
  localparam logic       c_ADR_RESULT   = 1'b1;
  localparam logic [1:0] c_PC_INCREMENT = 2'd0;
  localparam logic [1:0] c_PC_JUMP      = 2'd1;
  localparam logic [1:0] c_PC_ALU       = 2'd2;
  localparam logic [1:0] c_A_RD1        = 2'd0;
  localparam logic [1:0] c_A_OLD_PC     = 2'd1;
  localparam logic [1:0] c_A_ZERO       = 2'd2;
  localparam logic [1:0] c_B_IMM_EXT    = 2'd0;
  localparam logic [1:0] c_B_RD2        = 2'd1;
  localparam logic [1:0] c_B_FOUR       = 2'd2;
  localparam logic [2:0] c_ALU_ADD      = 3'b000;
  localparam logic [2:0] c_ALU_SUB      = 3'b001;
  localparam logic [2:0] c_ALU_RTYPE    = 3'b010;
  localparam logic [2:0] c_ALU_ITYPE    = 3'b011;
  localparam logic       c_RES_ALU_OUT  = 1'b0;
  localparam logic       c_RES_DATA     = 1'b1;

  localparam logic       c_TIMEOUT_EN   = (MEM_HANDSHAKE != 0) && (MEM_TIMEOUT != 0);
  localparam logic [7:0] c_TIMEOUT_CNT  = 8'(MEM_TIMEOUT);
  localparam logic       c_TRAP_EN      = (TRAP_EN != 0);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_JAL       = 4'd3,
    S_EXEC_I    = 4'd4,
    S_MEM_ADR   = 4'd5,
    S_ALU_WB    = 4'd6,
    S_MEM_WRITE = 4'd7,
    S_MEM_READ  = 4'd8,
    S_MEM_WB    = 4'd9,
    S_BRANCH    = 4'd10,
    S_LUI       = 4'd11,
    S_AUIPC     = 4'd12,
    S_JALR_CALC = 4'd13,
    S_JALR_LINK = 4'd14,
    S_TRAP      = 4'd15
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait_cnt;
  logic       r_illegal;
  logic       r_bus_error;

  logic       w_ready;
  logic       w_wait_state;
  logic       w_timeout;
  logic       w_illegal;
  logic       w_taken;

  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_pc_update;
  logic       w_mem_write;
  logic       w_mem_read;

  // Without the handshake every access completes in one cycle.
  assign w_ready      = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;
  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                        (r_state == S_MEM_WRITE);
  // A late mem_ready in the timeout cycle still completes the access.
  assign w_timeout    = c_TIMEOUT_EN && w_wait_state && !w_ready &&
                        (r_wait_cnt == c_TIMEOUT_CNT);

  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000:  w_taken = zero_flag;
      3'b001:  w_taken = !zero_flag;
      3'b100:  w_taken = lt_flag;
      3'b101:  w_taken = !lt_flag;
      3'b110:  w_taken = ltu_flag;
      3'b111:  w_taken = !ltu_flag;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next       = r_state;
    w_illegal    = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_pc_update  = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_read   = 1'b0;
    branch       = 1'b0;
    pc_src       = c_PC_INCREMENT;
    adr_src      = c_ADR_PC;
    alu_src_a    = c_A_RD1;
    alu_src_b    = c_B_IMM_EXT;
    alu_op       = c_ALU_ADD;
    result_src   = c_RES_ALU_OUT;

    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_ir_write  = w_ready;
        w_pc_update = w_ready;
        if (w_timeout)    w_next = S_TRAP;
        else if (w_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        // OLD_PC + IMM precomputes the branch/jump target.
        alu_src_a = c_A_OLD_PC;
        case (opcode)
          c_OP_JAL:               w_next = S_JAL;
          c_OP_R:                 w_next = S_EXEC_R;
          c_OP_I:                 w_next = S_EXEC_I;
          c_OP_LOAD, c_OP_STORE:  w_next = S_MEM_ADR;
          c_OP_BRANCH: begin
            if (funct3[2:1] == 2'b01) w_illegal = 1'b1;
            else                      w_next    = S_BRANCH;
          end
          c_OP_AUIPC:             w_next = S_AUIPC;
          c_OP_LUI:               w_next = S_LUI;
          c_OP_JALR:              w_next = S_JALR_CALC;
          default:                w_illegal = 1'b1;
        endcase
        if (w_illegal) w_next = c_TRAP_EN ? S_TRAP : S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_b = c_B_RD2;
        alu_op    = c_ALU_RTYPE;
        w_next    = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_op = c_ALU_ITYPE;
        w_next = S_ALU_WB;
      end
      S_LUI: begin
        alu_src_a = c_A_ZERO;
        w_next    = S_ALU_WB;
      end
      S_AUIPC: begin
        alu_src_a = c_A_OLD_PC;
        w_next    = S_ALU_WB;
      end
      S_JAL: begin
        // Link value PC+4 is computed while the target is loaded into PC.
        alu_src_a   = c_A_OLD_PC;
        alu_src_b   = c_B_FOUR;
        pc_src      = c_PC_JUMP;
        w_pc_update = 1'b1;
        w_next      = S_ALU_WB;
      end
      S_JALR_CALC: begin
        w_next = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        alu_src_a   = c_A_OLD_PC;
        alu_src_b   = c_B_FOUR;
        pc_src      = c_PC_ALU;
        w_pc_update = 1'b1;
        w_next      = S_ALU_WB;
      end
      S_BRANCH: begin
        alu_src_b   = c_B_RD2;
        alu_op      = c_ALU_SUB;
        branch      = 1'b1;
        w_pc_update = 1'b1;
        pc_src      = w_taken ? c_PC_JUMP : c_PC_INCREMENT;
        w_next      = S_FETCH;
      end
      S_MEM_ADR: begin
        w_next = (opcode == c_OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        adr_src    = c_ADR_RESULT;
        w_mem_read = 1'b1;
        if (w_timeout)    w_next = S_TRAP;
        else if (w_ready) w_next = S_MEM_WB;
      end
      S_MEM_WRITE: begin
        adr_src     = c_ADR_RESULT;
        w_mem_write = 1'b1;
        if (w_timeout)    w_next = S_TRAP;
        else if (w_ready) w_next = S_FETCH;
      end
      S_MEM_WB: begin
        result_src  = c_RES_DATA;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_ALU_WB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_TRAP: begin
        w_next = S_TRAP;
      end
      default: begin
        w_next = S_TRAP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_wait_cnt  <= 8'd0;
      r_illegal   <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait_cnt <= 8'd0;
      else if (w_wait_state && !w_ready && (r_wait_cnt != 8'hFF))
        r_wait_cnt <= r_wait_cnt + 8'd1;
      if ((r_state == S_DECODE) && w_illegal && c_TRAP_EN)
        r_illegal <= 1'b1;
      if (w_timeout)
        r_bus_error <= 1'b1;
    end
  end

  // State may still hold a mid-access value while reset is asserted, so the
  // enables are gated directly rather than waiting for the state to clear.
  assign ir_write      = w_ir_write  & ~reset;
  assign reg_write     = w_reg_write & ~reset;
  assign pc_update     = w_pc_update & ~reset;
  assign mem_write     = w_mem_write & ~reset;
  assign mem_read      = w_mem_read  & ~reset;
  assign illegal_instr = r_illegal;
  assign bus_error     = r_bus_error;
  assign fsm_state     = {{(STATE_W-4){1'b0}}, r_state};

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_multicycle_ctrl_fsm
// Description : Directed self-checking bench for multicycle_ctrl_fsm. The
//               main instance uses MEM_TIMEOUT=4; a second instance with
//               TRAP_EN=0 and MEM_HANDSHAKE=0 shares the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero_flag, lt_flag, ltu_flag, mem_ready;

  logic       adr_src, ir_write, reg_write, pc_update, mem_write, mem_read, branch;
  logic [1:0] pc_src, alu_src_a, alu_src_b;
  logic [2:0] alu_op;
  logic       result_src, illegal_instr, bus_error;
  logic [4:0] fsm_state;

  logic       n_adr_src, n_ir_write, n_reg_write, n_pc_update, n_mem_write, n_mem_read, n_branch;
  logic [1:0] n_pc_src, n_alu_src_a, n_alu_src_b;
  logic [2:0] n_alu_op;
  logic       n_result_src, n_illegal_instr, n_bus_error;
  logic [4:0] n_fsm_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(
    .STATE_W(5), .MEM_HANDSHAKE(1), .MEM_TIMEOUT(4), .TRAP_EN(1)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .zero_flag(zero_flag), .lt_flag(lt_flag), .ltu_flag(ltu_flag), .mem_ready(mem_ready),
    .adr_src(adr_src), .ir_write(ir_write), .reg_write(reg_write), .pc_update(pc_update),
    .pc_src(pc_src), .mem_write(mem_write), .mem_read(mem_read), .branch(branch),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
    .illegal_instr(illegal_instr), .bus_error(bus_error), .fsm_state(fsm_state)
  );

  multicycle_ctrl_fsm #(
    .STATE_W(5), .MEM_HANDSHAKE(0), .MEM_TIMEOUT(4), .TRAP_EN(0)
  ) dut_n (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .zero_flag(zero_flag), .lt_flag(lt_flag), .ltu_flag(ltu_flag), .mem_ready(mem_ready),
    .adr_src(n_adr_src), .ir_write(n_ir_write), .reg_write(n_reg_write), .pc_update(n_pc_update),
    .pc_src(n_pc_src), .mem_write(n_mem_write), .mem_read(n_mem_read), .branch(n_branch),
    .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .alu_op(n_alu_op), .result_src(n_result_src),
    .illegal_instr(n_illegal_instr), .bus_error(n_bus_error), .fsm_state(n_fsm_state)
  );

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves both instances in FETCH, mid-cycle, reset released.
  task automatic do_reset();
    reset = 1'b1; mem_ready = 1'b1; opcode = OP_R; funct3 = 3'b000;
    zero_flag = 1'b0; lt_flag = 1'b0; ltu_flag = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; opcode = OP_R; funct3 = 3'b000;
    zero_flag = 1'b0; lt_flag = 1'b0; ltu_flag = 1'b0;
    tick(); tick(); #1;
    checks++;
    if (fsm_state !== 5'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", fsm_state);
    end
    checks++;
    if ({ir_write, reg_write, pc_update, mem_write, mem_read} !== 5'b0) begin
      errors++; $display("FAIL reset_enables: got %b expected 00000",
                         {ir_write, reg_write, pc_update, mem_write, mem_read});
    end
    checks++;
    if ({illegal_instr, bus_error} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got %b expected 00", {illegal_instr, bus_error});
    end
    reset = 1'b0; #1;
    checks++;
    if ({mem_read, ir_write, pc_update} !== 3'b111) begin
      errors++; $display("FAIL fetch_after_reset: got %b expected 111", {mem_read, ir_write, pc_update});
    end
  endtask

  task automatic test_add();
    do_reset();
    opcode = OP_R; #1;
    checks++;
    if ({fsm_state, ir_write, reg_write} !== {5'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL add_fetch: got st=%0d ir=%b rw=%b expected st=0 ir=1 rw=0",
                         fsm_state, ir_write, reg_write);
    end
    tick();
    checks++;
    if ({fsm_state, alu_src_a, reg_write} !== {5'd1, 2'd1, 1'b0}) begin
      errors++; $display("FAIL add_decode: got st=%0d a=%0d rw=%b expected st=1 a=1 rw=0",
                         fsm_state, alu_src_a, reg_write);
    end
    tick();
    checks++;
    if ({fsm_state, alu_op, alu_src_b, reg_write} !== {5'd2, 3'b010, 2'd1, 1'b0}) begin
      errors++; $display("FAIL add_exec_r: got st=%0d op=%b b=%0d rw=%b expected st=2 op=010 b=1 rw=0",
                         fsm_state, alu_op, alu_src_b, reg_write);
    end
    tick();
    checks++;
    if ({fsm_state, reg_write} !== {5'd6, 1'b1}) begin
      errors++; $display("FAIL add_alu_wb: got st=%0d rw=%b expected st=6 rw=1", fsm_state, reg_write);
    end
    tick();
    checks++;
    if ({fsm_state, reg_write} !== {5'd0, 1'b0}) begin
      errors++; $display("FAIL add_return: got st=%0d rw=%b expected st=0 rw=0", fsm_state, reg_write);
    end
  endtask

  // exp holds one state per nibble, first state in the lowest nibble.
  task automatic run_seq(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic [23:0] exp, input int len);
    do_reset();
    opcode = op; funct3 = f3; zero_flag = 1'b1;
    for (int i = 0; i < len; i++) begin
      if (i > 0) tick();
      #1;
      checks++;
      if (fsm_state !== {1'b0, exp[i*4 +: 4]}) begin
        errors++; $display("FAIL seq_%s[%0d]: got %0d expected %0d", name, i, fsm_state, exp[i*4 +: 4]);
      end
    end
  endtask

  task automatic test_sequences();
    run_seq("addi",  OP_I,      3'b000, 24'h006410, 5);
    run_seq("lui",   OP_LUI,    3'b000, 24'h006B10, 5);
    run_seq("auipc", OP_AUIPC,  3'b000, 24'h006C10, 5);
    run_seq("jal",   OP_JAL,    3'b000, 24'h006310, 5);
    run_seq("jalr",  OP_JALR,   3'b000, 24'h06ED10, 6);
    run_seq("lw",    OP_LOAD,   3'b010, 24'h098510, 6);
    run_seq("sw",    OP_STORE,  3'b010, 24'h007510, 5);
    run_seq("beq",   OP_BRANCH, 3'b000, 24'h000A10, 4);
  endtask

  task automatic test_load_wait();
    do_reset();
    opcode = OP_LOAD; funct3 = 3'b010;
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    checks++;
    if ({fsm_state, mem_read, adr_src} !== {5'd8, 1'b1, 1'b1}) begin
      errors++; $display("FAIL lw_mem_read: got st=%0d rd=%b adr=%b expected st=8 rd=1 adr=1",
                         fsm_state, mem_read, adr_src);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      mem_ready = (k == 3); #1;
      checks++;
      if ({fsm_state, mem_read} !== {5'd8, 1'b1}) begin
        errors++; $display("FAIL lw_wait%0d: got st=%0d rd=%b expected st=8 rd=1", k, fsm_state, mem_read);
      end
    end
    tick();
    checks++;
    if ({fsm_state, reg_write, result_src, mem_read} !== {5'd9, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL lw_mem_wb: got st=%0d rw=%b res=%b rd=%b expected st=9 rw=1 res=1 rd=0",
                         fsm_state, reg_write, result_src, mem_read);
    end
    tick();
    checks++;
    if (fsm_state !== 5'd0) begin
      errors++; $display("FAIL lw_return: got %0d expected 0", fsm_state);
    end
  endtask

  task automatic test_branch();
    // {funct3, zero, lt, ltu, expected pc_src}
    logic [8:0] vec [6] = '{
      {3'b110, 1'b0, 1'b0, 1'b1, 2'd1},
      {3'b101, 1'b0, 1'b1, 1'b0, 2'd0},
      {3'b000, 1'b1, 1'b0, 1'b0, 2'd1},
      {3'b001, 1'b1, 1'b0, 1'b0, 2'd0},
      {3'b100, 1'b0, 1'b1, 1'b0, 2'd1},
      {3'b111, 1'b0, 1'b0, 1'b0, 2'd1}
    };
    for (int i = 0; i < 6; i++) begin
      do_reset();
      opcode = OP_BRANCH;
      {funct3, zero_flag, lt_flag, ltu_flag} = vec[i][8:2];
      tick(); tick(); #1;
      checks++;
      if ({fsm_state, pc_update, branch, alu_op, pc_src} !== {5'd10, 1'b1, 1'b1, 3'b001, vec[i][1:0]}) begin
        errors++; $display("FAIL branch_f3_%b: got st=%0d pcu=%b br=%b op=%b pcsrc=%0d expected st=10 pcu=1 br=1 op=001 pcsrc=%0d",
                           funct3, fsm_state, pc_update, branch, alu_op, pc_src, vec[i][1:0]);
      end
      tick();
      checks++;
      if (fsm_state !== 5'd0) begin
        errors++; $display("FAIL branch_return_%b: got %0d expected 0", funct3, fsm_state);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = 7'b0000000;
    tick(); tick(); #1;
    checks++;
    if ({fsm_state, illegal_instr, bus_error} !== {5'd15, 1'b1, 1'b0}) begin
      errors++; $display("FAIL illegal_trap: got st=%0d ill=%b bus=%b expected st=15 ill=1 bus=0",
                         fsm_state, illegal_instr, bus_error);
    end
    checks++;
    if ({n_fsm_state, n_illegal_instr} !== {5'd0, 1'b0}) begin
      errors++; $display("FAIL illegal_nop: got st=%0d ill=%b expected st=0 ill=0", n_fsm_state, n_illegal_instr);
    end
    tick();
    checks++;
    if ({fsm_state, mem_read, ir_write, illegal_instr} !== {5'd15, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL trap_sticky: got st=%0d rd=%b ir=%b ill=%b expected st=15 rd=0 ir=0 ill=1",
                         fsm_state, mem_read, ir_write, illegal_instr);
    end
    do_reset();
    opcode = OP_BRANCH; funct3 = 3'b010;
    tick(); tick(); #1;
    checks++;
    if ({fsm_state, illegal_instr} !== {5'd15, 1'b1}) begin
      errors++; $display("FAIL branch_f3_010: got st=%0d ill=%b expected st=15 ill=1", fsm_state, illegal_instr);
    end
  endtask

  task automatic test_no_handshake();
    do_reset();
    mem_ready = 1'b0; opcode = OP_R;
    tick(); #1;
    checks++;
    if ({fsm_state, n_fsm_state} !== {5'd0, 5'd1}) begin
      errors++; $display("FAIL fetch_wait: got main=%0d nohs=%0d expected main=0 nohs=1", fsm_state, n_fsm_state);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    opcode = OP_STORE; funct3 = 3'b010;
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) tick();
      checks++;
      if ({fsm_state, mem_write, adr_src} !== {5'd7, 1'b1, 1'b1}) begin
        errors++; $display("FAIL sw_wait%0d: got st=%0d wr=%b adr=%b expected st=7 wr=1 adr=1",
                           k, fsm_state, mem_write, adr_src);
      end
    end
    tick();
    checks++;
    if ({fsm_state, bus_error, illegal_instr, mem_write} !== {5'd15, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL timeout_trap: got st=%0d bus=%b ill=%b wr=%b expected st=15 bus=1 ill=0 wr=0",
                         fsm_state, bus_error, illegal_instr, mem_write);
    end
    mem_ready = 1'b1;
    tick();
    checks++;
    if ({fsm_state, bus_error, mem_write} !== {5'd15, 1'b1, 1'b0}) begin
      errors++; $display("FAIL timeout_sticky: got st=%0d bus=%b wr=%b expected st=15 bus=1 wr=0",
                         fsm_state, bus_error, mem_write);
    end
  endtask

  // mem_ready arriving in the same cycle as the timeout wins.
  task automatic test_timeout_race();
    do_reset();
    opcode = OP_STORE; funct3 = 3'b010;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      mem_ready = (k == 4);
    end
    tick();
    checks++;
    if ({fsm_state, bus_error} !== {5'd0, 1'b0}) begin
      errors++; $display("FAIL timeout_race: got st=%0d bus=%b expected st=0 bus=0", fsm_state, bus_error);
    end
  endtask

  task automatic test_reset_in_mem_write();
    do_reset();
    opcode = OP_STORE; funct3 = 3'b010;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    tick(); tick();
    reset = 1'b1; #1;
    checks++;
    if ({fsm_state, mem_write} !== {5'd7, 1'b0}) begin
      errors++; $display("FAIL reset_in_memwrite: got st=%0d wr=%b expected st=7 wr=0", fsm_state, mem_write);
    end
    tick();
    reset = 1'b0; #1;
    checks++;
    if ({fsm_state, bus_error, illegal_instr, mem_read} !== {5'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset_release: got st=%0d bus=%b ill=%b rd=%b expected st=0 bus=0 ill=0 rd=1",
                         fsm_state, bus_error, illegal_instr, mem_read);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sequences();
    test_load_wait();
    test_branch();
    test_illegal();
    test_no_handshake();
    test_timeout();
    test_timeout_race();
    test_reset_in_mem_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 ns");
    $fatal(1);
  end

endmodule
`default_nettype wire
